intc: RTL

//  Interrupt controller that collects peripheral interrupt lines (timer_int and others) and forwards one

---
 rtl/intc_pkg.sv | 23 ++
 rtl/intc_prio_enc.sv | 24 ++
 rtl/intc.sv | 115 +++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared register offsets, base address, claim-id width and FSM encodings for the interrupt controller.
// Pure definitions: no logic, no latency, no flow control.
package intc_pkg;

  localparam logic [31:0] INTC_BASE  = 32'hffff0040;
  localparam logic [3:0]  INTC_PEND  = 4'h0;
  localparam logic [3:0]  INTC_ENAB  = 4'h4;
  localparam logic [3:0]  INTC_CLAIM = 4'h8;
  localparam logic [3:0]  INTC_CMPL  = 4'hC;

  // Up to 31 sources, so an index always fits in 5 bits.
  localparam int ID_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] off);
    return base | {28'd0, off};
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Priority encoder: lowest set bit of i_vec wins. Purely combinational, zero latency, no backpressure.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    i_vec,
  output logic            o_vld,
  output logic [ID_W-1:0] o_idx
);

  // Scan from the top so the lowest index is the last assignment and therefore wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_vld = 1'b1;
        o_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc.sv
// Interrupt controller: edge-latched pending bits, enable mask, claim/complete handshake over the tri-state bus.
// Reads are combinational; cpu_irq is registered and appears two cycles after a source edge; the bus has no backpressure.
module intc
  import intc_pkg::*;
#(
  parameter int          NUM_SRC = 8,
  parameter logic [31:0] BASE    = INTC_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  inout  wire  [31:0]        mem_data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_enab;
  logic [ID_W-1:0]    r_cur_id;
  logic               r_claim_q;
  logic               r_irq;
  state_t             r_state;

  state_t             w_state_nxt;
  logic               w_irq_nxt;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_act;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_claim_clr;
  logic               w_vld;
  logic [ID_W-1:0]    w_idx;
  logic               w_hit_pend;
  logic               w_hit_enab;
  logic               w_hit_claim;
  logic               w_hit_cmpl;
  logic               w_rd;
  logic               w_claim_rd;
  logic               w_claim_fire;
  logic               w_cmpl_ok;
  logic [31:0]        w_rd_dat;

  assign w_hit_pend  = (mem_addr == reg_addr(BASE, INTC_PEND));
  assign w_hit_enab  = (mem_addr == reg_addr(BASE, INTC_ENAB));
  assign w_hit_claim = (mem_addr == reg_addr(BASE, INTC_CLAIM));
  assign w_hit_cmpl  = (mem_addr == reg_addr(BASE, INTC_CMPL));

  assign w_rise = irq_src & ~r_src_q;
  assign w_act  = r_pend & r_enab;

  intc_prio_enc #(.N(NUM_SRC)) u_prio_enc (
    .i_vec (w_act),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  // A held CLAIM address only acts on its first cycle.
  assign w_claim_rd   = !mem_we && w_hit_claim;
  assign w_claim_fire = w_claim_rd && !r_claim_q && (r_state == IDLE) && w_vld;
  assign w_claim_clr  = w_claim_fire ? (NUM_SRC'(1) << w_idx) : '0;
  assign w_w1c        = (mem_we && w_hit_pend) ? mem_data[NUM_SRC-1:0] : '0;
  assign w_cmpl_ok    = mem_we && w_hit_cmpl && (mem_data == 32'(r_cur_id) + 32'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_irq_nxt = |w_act;
        if (w_claim_fire) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_cmpl_ok) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_src_q   <= '0;
      r_pend    <= '0;
      r_enab    <= '0;
      r_cur_id  <= '0;
      r_claim_q <= 1'b0;
      r_irq     <= 1'b0;
      r_state   <= IDLE;
    end else begin
      r_src_q   <= irq_src;
      // The rise term is OR'ed last so a same-cycle edge beats a clear.
      r_pend    <= (r_pend & ~w_w1c & ~w_claim_clr) | w_rise;
      if (mem_we && w_hit_enab) r_enab <= mem_data[NUM_SRC-1:0];
      if (w_claim_fire) r_cur_id <= w_idx;
      r_claim_q <= w_claim_rd;
      r_irq     <= w_irq_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign cpu_irq = r_irq;

  always_comb begin
    w_rd_dat = '0;
    if (w_hit_pend)                       w_rd_dat = 32'(r_pend);
    else if (w_hit_enab)                  w_rd_dat = 32'(r_enab);
    else if (w_hit_claim && w_claim_fire) w_rd_dat = 32'(w_idx) + 32'd1;
  end

  assign w_rd     = !mem_we && (w_hit_pend || w_hit_enab || w_hit_claim || w_hit_cmpl);
  assign mem_data = w_rd ? w_rd_dat : 32'bz;

endmodule
